// File: rtl/alarm_led_pkg.sv
// ============================================================================
// Module      : alarm_led_pkg
// Description : Shared state, request-priority and LED colour definitions.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alarm_led_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_ALARM    = 3'd3,
    ST_DISARMED = 3'd4,
    ST_TEST     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    REQ_NONE    = 3'd0,
    REQ_DISARM  = 3'd1,
    REQ_TRIGGER = 3'd2,
    REQ_ARM     = 3'd3,
    REQ_TEST    = 3'd4
  } req_e;

  // Bit positions in the request vector; higher bit wins.
  localparam int c_REQ_BIT_DISARM  = 3;
  localparam int c_REQ_BIT_TRIGGER = 2;
  localparam int c_REQ_BIT_ARM     = 1;
  localparam int c_REQ_BIT_TEST    = 0;

  localparam logic [2:0] c_COLOR_OFF    = 3'b000;
  localparam logic [2:0] c_COLOR_WHITE  = 3'b001;
  localparam logic [2:0] c_COLOR_YELLOW = 3'b010;
  localparam logic [2:0] c_COLOR_CYAN   = 3'b011;
  localparam logic [2:0] c_COLOR_RED    = 3'b100;
  localparam logic [2:0] c_COLOR_GREEN  = 3'b110;

  function automatic req_e top_request(input logic [3:0] reqs);
    if (reqs[c_REQ_BIT_DISARM])       return REQ_DISARM;
    else if (reqs[c_REQ_BIT_TRIGGER]) return REQ_TRIGGER;
    else if (reqs[c_REQ_BIT_ARM])     return REQ_ARM;
    else if (reqs[c_REQ_BIT_TEST])    return REQ_TEST;
    else                              return REQ_NONE;
  endfunction

  // Requests a state listens to; everything else is ignored before arbitration.
  function automatic logic [3:0] req_mask(input state_e st);
    logic [3:0] m;
    m = '0;
    case (st)
      ST_IDLE:     begin m[c_REQ_BIT_ARM] = 1'b1; m[c_REQ_BIT_TEST] = 1'b1; end
      ST_ARMED:    begin m[c_REQ_BIT_DISARM] = 1'b1; m[c_REQ_BIT_TRIGGER] = 1'b1; end
      ST_ENTRY:    m[c_REQ_BIT_DISARM] = 1'b1;
      ST_ALARM:    m[c_REQ_BIT_DISARM] = 1'b1;
      ST_DISARMED: m[c_REQ_BIT_ARM] = 1'b1;
      ST_TEST:     m[c_REQ_BIT_ARM] = 1'b1;
      default:     m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] color_of(input state_e st);
    case (st)
      ST_ARMED:    return c_COLOR_CYAN;
      ST_ENTRY:    return c_COLOR_YELLOW;
      ST_ALARM:    return c_COLOR_RED;
      ST_DISARMED: return c_COLOR_GREEN;
      ST_TEST:     return c_COLOR_WHITE;
      default:     return c_COLOR_OFF;
    endcase
  endfunction

  function automatic logic is_timed(input state_e st);
    return (st == ST_ENTRY) || (st == ST_DISARMED) || (st == ST_TEST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_led_timer.sv
// ============================================================================
// Module      : alarm_led_timer
// Description : Loadable down-counter that stops at zero; clear beats load.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alarm_led_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count   = r_count;
  assign expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/alarm_led_sequencer.sv
// ============================================================================
// Module      : alarm_led_sequencer
// Description : Alarm panel state machine driving an RGB LED mode code.
//               Define ALARM_LED_SEQUENCER_TEST_EN to build in the lamp test.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alarm_led_sequencer
  import alarm_led_pkg::*;
#(
  parameter int ENTRY_DELAY_CYC  = 500000000,
  parameter int SUCCESS_HOLD_CYC = 100000000,
  parameter int TEST_HOLD_CYC    = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm_req,
  input  logic       disarm_req,
  input  logic       trigger,
  input  logic       test_req,
  output logic [2:0] color_code,
  output logic [2:0] state,
  output logic       alarm_active,
  output logic       timer_busy
);

  localparam int c_MAX_CYC = (ENTRY_DELAY_CYC > SUCCESS_HOLD_CYC)
                           ? ((ENTRY_DELAY_CYC > TEST_HOLD_CYC) ? ENTRY_DELAY_CYC : TEST_HOLD_CYC)
                           : ((SUCCESS_HOLD_CYC > TEST_HOLD_CYC) ? SUCCESS_HOLD_CYC : TEST_HOLD_CYC);
  localparam int c_TIMER_W = $clog2(c_MAX_CYC) + 1;

  localparam logic [c_TIMER_W-1:0] c_ENTRY_LOAD  = c_TIMER_W'(ENTRY_DELAY_CYC - 1);
  localparam logic [c_TIMER_W-1:0] c_DISARM_LOAD = c_TIMER_W'(SUCCESS_HOLD_CYC - 1);
`ifdef ALARM_LED_SEQUENCER_TEST_EN
  localparam logic [c_TIMER_W-1:0] c_TEST_LOAD   = c_TIMER_W'(TEST_HOLD_CYC - 1);
`endif

  state_e                 r_state;
  logic [2:0]             r_color;
  logic                   r_alarm;
  state_e                 w_next;
  req_e                   w_req;
  logic [3:0]             w_reqs;
  logic                   w_test_req;
  logic                   w_load;
  logic                   w_clear;
  logic [c_TIMER_W-1:0]   w_load_val;
  logic [c_TIMER_W-1:0]   w_count;
  logic                   w_expired;

`ifdef ALARM_LED_SEQUENCER_TEST_EN
  assign w_test_req = test_req;
`else
  assign w_test_req = test_req & 1'b0;
`endif

  always_comb begin
    w_reqs     = {disarm_req, trigger, arm_req, w_test_req} & req_mask(r_state);
    w_req      = top_request(w_reqs);
    w_next     = r_state;
    w_load_val = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_req == REQ_ARM) w_next = ST_ARMED;
`ifdef ALARM_LED_SEQUENCER_TEST_EN
        else if (w_req == REQ_TEST) w_next = ST_TEST;
`endif
      end
      ST_ARMED: begin
        if (w_req == REQ_DISARM)       w_next = ST_DISARMED;
        else if (w_req == REQ_TRIGGER) w_next = ST_ENTRY;
      end
      // Disarm beats expiry in the final entry cycle.
      ST_ENTRY: begin
        if (w_req == REQ_DISARM) w_next = ST_DISARMED;
        else if (w_expired)      w_next = ST_ALARM;
      end
      ST_ALARM: begin
        if (w_req == REQ_DISARM) w_next = ST_DISARMED;
      end
      ST_DISARMED: begin
        if (w_req == REQ_ARM) w_next = ST_ARMED;
        else if (w_expired)   w_next = ST_IDLE;
      end
`ifdef ALARM_LED_SEQUENCER_TEST_EN
      ST_TEST: begin
        if (w_req == REQ_ARM) w_next = ST_ARMED;
        else if (w_expired)   w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase

    w_load  = is_timed(w_next) && (w_next != r_state);
    w_clear = is_timed(r_state) && !is_timed(w_next);

    case (w_next)
      ST_ENTRY:    w_load_val = c_ENTRY_LOAD;
      ST_DISARMED: w_load_val = c_DISARM_LOAD;
`ifdef ALARM_LED_SEQUENCER_TEST_EN
      ST_TEST:     w_load_val = c_TEST_LOAD;
`endif
      default:     w_load_val = '0;
    endcase
  end

  // Outputs are registered from the next state so they move on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_color <= c_COLOR_OFF;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_next;
      r_color <= color_of(w_next);
      r_alarm <= (w_next == ST_ALARM);
    end
  end

  alarm_led_timer #(
    .WIDTH (c_TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .value   (w_load_val),
    .clear   (w_clear),
    .count   (w_count),
    .expired (w_expired)
  );

  assign state        = r_state;
  assign color_code   = r_color;
  assign alarm_active = r_alarm;
  assign timer_busy   = (w_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_alarm_led_sequencer.sv
// ============================================================================
// Module      : tb_alarm_led_sequencer
// Description : Directed bench with a cycle-level behavioural reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alarm_led_sequencer;
  import alarm_led_pkg::*;

  localparam int ENTRY_N = 8;
  localparam int DIS_N   = 4;
  localparam int TEST_N  = 3;
`ifdef ALARM_LED_SEQUENCER_TEST_EN
  localparam bit TEST_ON = 1'b1;
`else
  localparam bit TEST_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm_req = 1'b0;
  logic       disarm_req = 1'b0;
  logic       trigger = 1'b0;
  logic       test_req = 1'b0;
  logic [2:0] color_code;
  logic [2:0] state;
  logic       alarm_active;
  logic       timer_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alarm_led_sequencer #(
    .ENTRY_DELAY_CYC  (ENTRY_N),
    .SUCCESS_HOLD_CYC (DIS_N),
    .TEST_HOLD_CYC    (TEST_N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm_req      (arm_req),
    .disarm_req   (disarm_req),
    .trigger      (trigger),
    .test_req     (test_req),
    .color_code   (color_code),
    .state        (state),
    .alarm_active (alarm_active),
    .timer_busy   (timer_busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: current mode plus cycles remaining in it (0 for untimed modes).
  typedef struct packed {
    state_e mode;
    int     left;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t cur, input logic d, input logic t,
                                  input logic a, input logic te);
    model_t n;
    n.mode = cur.mode;
    n.left = (cur.left > 0) ? cur.left - 1 : 0;
    case (cur.mode)
      ST_IDLE: begin
        if (a) begin n.mode = ST_ARMED; n.left = 0; end
        else if (te && TEST_ON) begin n.mode = ST_TEST; n.left = TEST_N; end
      end
      ST_ARMED: begin
        if (d) begin n.mode = ST_DISARMED; n.left = DIS_N; end
        else if (t) begin n.mode = ST_ENTRY; n.left = ENTRY_N; end
      end
      ST_ENTRY: begin
        if (d) begin n.mode = ST_DISARMED; n.left = DIS_N; end
        else if (cur.left == 1) begin n.mode = ST_ALARM; n.left = 0; end
      end
      ST_ALARM: begin
        if (d) begin n.mode = ST_DISARMED; n.left = DIS_N; end
      end
      ST_DISARMED: begin
        if (a) begin n.mode = ST_ARMED; n.left = 0; end
        else if (cur.left == 1) begin n.mode = ST_IDLE; n.left = 0; end
      end
      ST_TEST: begin
        if (a) begin n.mode = ST_ARMED; n.left = 0; end
        else if (cur.left == 1) begin n.mode = ST_IDLE; n.left = 0; end
      end
      default: begin n.mode = ST_IDLE; n.left = 0; end
    endcase
    return n;
  endfunction

  function automatic int exp_color(input state_e s);
    case (s)
      ST_ARMED:    return 3;  // 011 cyan
      ST_ENTRY:    return 2;  // 010 yellow
      ST_ALARM:    return 4;  // 100 red
      ST_DISARMED: return 6;  // 110 green
      ST_TEST:     return 1;  // 001 white
      default:     return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{mode: ST_IDLE, left: 0};
    end else begin
      m <= step(m, disarm_req, trigger, arm_req, test_req);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_color", int'(color_code), exp_color(m.mode));
      check("model_state", int'(state), int'(m.mode));
      check("model_alarm", int'(alarm_active), int'(m.mode == ST_ALARM));
      check("model_busy", int'(timer_busy), int'(m.left > 1));
    end
  end

  // Drive one request cycle starting at a falling edge.
  task automatic pulse(input logic d, input logic t, input logic a, input logic te);
    disarm_req = d; trigger = t; arm_req = a; test_req = te;
    @(negedge clk);
    disarm_req = 1'b0; trigger = 1'b0; arm_req = 1'b0; test_req = 1'b0;
  endtask

  task automatic count_color(input logic [2:0] c, output int n);
    n = 0;
    while (color_code == c && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_color", int'(color_code), 0);
    check("rst_state", int'(state), int'(ST_IDLE));
    check("rst_alarm", int'(alarm_active), 0);
    check("rst_busy", int'(timer_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Arm, trigger, no disarm: 8 yellow cycles then latched alarm.
    pulse(0, 0, 1, 0);
    check("armed_color", int'(color_code), 3);
    pulse(0, 1, 0, 0);
    count_color(3'b010, n);
    check("entry_len", n, 8);
    check("alarm_color", int'(color_code), 4);
    check("alarm_active", int'(alarm_active), 1);
    repeat (10) @(negedge clk);
    check("alarm_hold_color", int'(color_code), 4);
    check("alarm_hold_active", int'(alarm_active), 1);

    // Disarm with a coincident trigger while alarming.
    pulse(1, 1, 0, 0);
    check("alarm_exit_active", int'(alarm_active), 0);
    check("alarm_exit_color", int'(color_code), 6);
    count_color(3'b110, n);
    check("disarmed_len", n, 4);
    check("disarmed_to_idle", int'(color_code), 0);

    // Disarm on the final entry cycle wins over expiry.
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    repeat (7) @(negedge clk);
    check("entry_cycle8", int'(color_code), 2);
    pulse(1, 0, 0, 0);
    check("late_disarm_color", int'(color_code), 6);
    check("late_disarm_alarm", int'(alarm_active), 0);
    count_color(3'b110, n);
    check("late_disarm_len", n, 4);
    check("late_disarm_idle", int'(color_code), 0);

    // Re-arm on the second disarmed cycle abandons the hold timer.
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    check("disarmed_busy", int'(timer_busy), 1);
    @(negedge clk);
    pulse(0, 0, 1, 0);
    check("rearm_color", int'(color_code), 3);
    check("rearm_busy", int'(timer_busy), 0);
    repeat (6) @(negedge clk);
    check("rearm_stays", int'(color_code), 3);
    pulse(1, 0, 0, 0);
    count_color(3'b110, n);
    check("rearm_disarm_len", n, 4);

    // Lamp test from idle.
    pulse(0, 0, 0, 1);
    if (TEST_ON) begin
      count_color(3'b001, n);
      check("test_len", n, 3);
      check("test_end_color", int'(color_code), 0);
    end else begin
      check("test_ignored", int'(color_code), 0);
      repeat (3) @(negedge clk);
      check("test_ignored_later", int'(color_code), 0);
    end

    // Asynchronous reset in the middle of the entry delay.
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", int'(timer_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_color", int'(color_code), 0);
    check("async_rst_state", int'(state), int'(ST_IDLE));
    check("async_rst_alarm", int'(alarm_active), 0);
    check("async_rst_busy", int'(timer_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_color", int'(color_code), 0);
    check("post_rst_state", int'(state), int'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_led_sequencer.md
ALARM_LED_SEQUENCER -- requirements
Module: alarm_led_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock and reset ports are named clk and rst_n.
REQ-002 The block SHALL provide parameter ENTRY_DELAY_CYC, default 500000000, giving the ENTRY state duration in cycles (10 s at 50 MHz).
REQ-003 The block SHALL provide parameter SUCCESS_HOLD_CYC, default 100000000, giving the DISARMED display duration in cycles.
REQ-004 The block SHALL provide parameter TEST_HOLD_CYC, default 50000000, giving the TEST display duration in cycles.
REQ-005 The block SHALL have these ports, one per line as name, direction, width and meaning:
- clk  in  1  50 MHz clock.
- rst_n  in  1  asynchronous active-low reset.
- arm_req  in  1  single-cycle arm request.
- disarm_req  in  1  single-cycle disarm request (valid code entered).
- trigger  in  1  single-cycle sensor trip.
- test_req  in  1  single-cycle lamp-test request.
- color_code  out  3  mode code driven to the RGB LED controller.
- state  out  3  current state encoding.
- alarm_active  out  1  high only in ALARM.
- timer_busy  out  1  high while the hold/delay timer is nonzero.

Function
REQ-006 The state machine SHALL have these states, each with a fixed color_code: IDLE=000 (off), ARMED=011 (cyan), ENTRY=010 (yellow), ALARM=100 (red blink), DISARMED=110 (green), TEST=001 (white).
REQ-007 The block SHALL evaluate requests simultaneous in one cycle with the priority disarm_req > trigger > arm_req > test_req.
REQ-008 In IDLE: arm_req SHALL go to ARMED, test_req SHALL go to TEST, and disarm_req and trigger SHALL be ignored.
REQ-009 In ARMED: disarm_req SHALL go to DISARMED, trigger SHALL go to ENTRY, and arm_req and test_req SHALL be ignored.
REQ-010 In ENTRY: disarm_req SHALL go to DISARMED; otherwise timer expiry SHALL go to ALARM; a repeated trigger SHALL NOT restart the timer.
REQ-011 In ALARM: only disarm_req SHALL cause an exit, to DISARMED.
REQ-012 In DISARMED: arm_req SHALL go to ARMED immediately and abandon the timer; otherwise timer expiry SHALL go to IDLE; disarm_req SHALL be ignored.
REQ-013 In TEST: arm_req SHALL go to ARMED; otherwise timer expiry SHALL go to IDLE.
REQ-014 On entry to a timed state with duration N, the timer SHALL load N-1 and decrement every cycle, so the state lasts exactly N cycles when no exit request arrives.
REQ-015 When disarm_req coincides with ENTRY timer expiry, the block SHALL go to DISARMED, not ALARM.
REQ-016 On every exit from a timed state, the timer SHALL be cleared to 0.
REQ-017 color_code, state and alarm_active SHALL be registered and SHALL change on the same clock edge as the state transition (one-cycle latency from the request).
REQ-018 timer_busy SHALL be asserted exactly when the timer is nonzero.
REQ-019 The timer width SHALL be $clog2 of the largest duration parameter plus 1; every parameter SHALL be at least 1.

Reset
REQ-020 While rst_n is low, the block SHALL hold state=IDLE, color_code=000, alarm_active=0, timer=0 and timer_busy=0, asynchronously.
REQ-021 A reset asserted mid-operation, including in ALARM or ENTRY, SHALL abandon the operation, and after release the block SHALL start from IDLE.

Configuration
REQ-022 With macro ALARM_LED_SEQUENCER_TEST_EN defined, the TEST state and its timer path SHALL be compiled in.
REQ-023 Without ALARM_LED_SEQUENCER_TEST_EN, the test_req port SHALL remain present but be ignored, TEST SHALL be unreachable, and code 001 SHALL never be output.

Structure
REQ-024 The state enum, the color-code constants (000/001/010/011/100/110) and the request-priority ordering SHALL reside in the shared package alarm_led_pkg.
REQ-025 The loadable down-counter SHALL be the sub-module alarm_led_timer, with inputs load, value and clear, and outputs count and expired.

Verification
REQ-026 With ENTRY_DELAY_CYC=8, SUCCESS_HOLD_CYC=4 and TEST_HOLD_CYC=3, the bench SHALL cover these directed scenarios:
- Stimulus: arm_req, then trigger, with no disarm. Required: ENTRY color 010 for exactly 8 cycles, then ALARM with color_code=100 and alarm_active=1 held indefinitely.
- Stimulus: disarm_req on the 8th ENTRY cycle, coincident with expiry. Required: DISARMED with 110 for 4 cycles, then IDLE with 000; ALARM is never entered.
- Stimulus: in ALARM, disarm_req and trigger in the same cycle. Required: DISARMED next cycle; alarm_active drops to 0 on that edge.
- Stimulus: arm_req on the 2nd DISARMED cycle. Required: ARMED with 011 next cycle and timer_busy=0.
- Stimulus: test_req in IDLE. Required: with ALARM_LED_SEQUENCER_TEST_EN, 001 for 3 cycles then 000; without it, color_code stays 000.
- Stimulus: rst_n pulled low during ENTRY. Required: color_code=000 and state=IDLE immediately, with no clock edge needed.
